// File: rtl/response_frame_queue.sv
// Response frame queue: buffers (code, data) responses from the command decoder and
// streams each one to the UART TX as [code, data bytes MSB first, optional XOR checksum].
//
// state | meaning
// IDLE  | no frame in flight; pops the FIFO head when one is available
// CODE  | presenting the response code byte
// DATA  | presenting data bytes, MSB first
// CSUM  | presenting the XOR checksum byte
module response_frame_queue #(
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH       = 4,
   parameter bit CHECKSUM_EN = 1'b1
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  push_i,
   input  logic [7:0]            response_code_i,
   input  logic [DATA_WIDTH-1:0] response_data_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  overflow_o,
   input  logic                  tx_ready_i,
   output logic                  tx_valid_o,
   output logic [7:0]            tx_byte_o,
   output logic                  busy_o,
   output logic [1:0]            debug_state_o
);

   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int NB  = DATA_WIDTH / 8;
   localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CODE = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_CSUM = 2'd3;

   logic [7:0]            code_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;

   logic [1:0]            state_q, state_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [7:0]            tx_byte_q, tx_byte_d;
   logic [DATA_WIDTH-1:0] frame_data_q, frame_data_d;
   logic [7:0]            csum_q, csum_d;
   logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;

   logic                  pop;
   logic                  push_ok;
   logic                  handshake;

   function automatic logic [7:0] frame_xor(input logic [7:0]            code,
                                            input logic [DATA_WIDTH-1:0] data);
      logic [7:0] acc;
      acc = code;
      for (int i = 0; i < NB; i++) begin
         acc = acc ^ data[8*i +: 8];
      end
      return acc;
   endfunction

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign handshake = tx_valid_q && tx_ready_i;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok   = push_i && (!full_o || pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else if (push_i) begin
         overflow_d = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i && push_ok) begin
         code_mem_q[wr_ptr_q] <= response_code_i;
         data_mem_q[wr_ptr_q] <= response_data_i;
      end
   end

   // The frame is copied out of the FIFO on pop, so later pushes cannot disturb it.
   always_comb begin
      state_d      = state_q;
      tx_valid_d   = tx_valid_q;
      tx_byte_d    = tx_byte_q;
      frame_data_d = frame_data_q;
      csum_d       = csum_q;
      byte_cnt_d   = byte_cnt_q;
      pop          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty_o) begin
               pop          = 1'b1;
               state_d      = ST_CODE;
               tx_valid_d   = 1'b1;
               tx_byte_d    = code_mem_q[rd_ptr_q];
               frame_data_d = data_mem_q[rd_ptr_q];
               csum_d       = frame_xor(code_mem_q[rd_ptr_q], data_mem_q[rd_ptr_q]);
            end
         end
         ST_CODE: begin
            if (handshake) begin
               state_d      = ST_DATA;
               tx_byte_d    = frame_data_q[DATA_WIDTH-1 -: 8];
               frame_data_d = frame_data_q << 8;
               byte_cnt_d   = BCW'(NB - 1);
            end
         end
         ST_DATA: begin
            if (handshake) begin
               // byte_cnt_q counts data bytes still to follow the one on the bus
               if (byte_cnt_q == '0) begin
                  if (CHECKSUM_EN) begin
                     state_d   = ST_CSUM;
                     tx_byte_d = csum_q;
                  end else begin
                     state_d    = ST_IDLE;
                     tx_valid_d = 1'b0;
                  end
               end else begin
                  tx_byte_d    = frame_data_q[DATA_WIDTH-1 -: 8];
                  frame_data_d = frame_data_q << 8;
                  byte_cnt_d   = byte_cnt_q - BCW'(1);
               end
            end
         end
         ST_CSUM: begin
            if (handshake) begin
               state_d    = ST_IDLE;
               tx_valid_d = 1'b0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         state_q      <= ST_IDLE;
         tx_valid_q   <= 1'b0;
         tx_byte_q    <= 8'h00;
         frame_data_q <= '0;
         csum_q       <= 8'h00;
         byte_cnt_q   <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         state_q      <= state_d;
         tx_valid_q   <= tx_valid_d;
         tx_byte_q    <= tx_byte_d;
         frame_data_q <= frame_data_d;
         csum_q       <= csum_d;
         byte_cnt_q   <= byte_cnt_d;
      end
   end

   assign overflow_o    = overflow_q;
   assign tx_valid_o    = tx_valid_q;
   assign tx_byte_o     = tx_byte_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign debug_state_o = state_q;

endmodule

// File: tb/tb_response_frame_queue.sv
// Bench for response_frame_queue: directed tables and sequences plus randomized traffic
// checked against a frame-level queue model.
module tb_response_frame_queue;

   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int NB    = DW / 8;
   localparam int FLEN  = 1 + NB + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          push, rdy;
   logic [7:0]    code;
   logic [DW-1:0] data;
   logic          full, empty, ovf, txv, busy;
   logic [7:0]    txb;
   logic [1:0]    dst;

   logic          push8, rdy8;
   logic [7:0]    code8, data8;
   logic          full8, empty8, ovf8, txv8, busy8;
   logic [7:0]    txb8;
   logic [1:0]    dst8;

   response_frame_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CHECKSUM_EN(1'b1)) dut (
      .clock_i(clk), .reset_i(rst_n), .push_i(push), .response_code_i(code),
      .response_data_i(data), .full_o(full), .empty_o(empty), .overflow_o(ovf),
      .tx_ready_i(rdy), .tx_valid_o(txv), .tx_byte_o(txb), .busy_o(busy),
      .debug_state_o(dst));

   response_frame_queue #(.DATA_WIDTH(8), .DEPTH(4), .CHECKSUM_EN(1'b0)) dut8 (
      .clock_i(clk), .reset_i(rst_n), .push_i(push8), .response_code_i(code8),
      .response_data_i(data8), .full_o(full8), .empty_o(empty8), .overflow_o(ovf8),
      .tx_ready_i(rdy8), .tx_valid_o(txv8), .tx_byte_o(txb8), .busy_o(busy8),
      .debug_state_o(dst8));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]    c;
      logic [DW-1:0] d;
   } entry_t;

   entry_t     m_fifo[$];
   logic [7:0] m_out[$];
   logic       m_ovf;
   logic [7:0] got[$];

   typedef struct {
      logic          p;
      logic [7:0]    c;
      logic [DW-1:0] d;
      logic          r;
      logic          ev;
      logic [7:0]    eb;
      logic          ee;
      logic [1:0]    es;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic build_frame(input entry_t e);
      logic [7:0] x;
      m_out.push_back(e.c);
      x = e.c;
      for (int i = NB - 1; i >= 0; i--) begin
         m_out.push_back(e.d[8*i +: 8]);
         x = x ^ e.d[8*i +: 8];
      end
      m_out.push_back(x);
   endtask

   // Frame-level model: an empty byte queue means IDLE, and IDLE always pops a waiting entry.
   task automatic model_edge();
      bit     hs, pop, acc;
      entry_t e;
      if (!rst_n) begin
         m_fifo.delete();
         m_out.delete();
         m_ovf = 1'b0;
         return;
      end
      hs  = (m_out.size() > 0) && rdy;
      pop = (m_out.size() == 0) && (m_fifo.size() > 0);
      acc = push && ((m_fifo.size() < DEPTH) || pop);
      if (hs) void'(m_out.pop_front());
      if (pop) begin
         e = m_fifo.pop_front();
         build_frame(e);
      end
      if (acc) begin
         e.c = code;
         e.d = data;
         m_fifo.push_back(e);
      end else if (push) begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic model_compare();
      int ev, es;
      ev = (m_out.size() > 0) ? 1 : 0;
      if (m_out.size() == 0)         es = 0;
      else if (m_out.size() == FLEN) es = 1;
      else if (m_out.size() == 1)    es = 3;
      else                           es = 2;
      check("m_tx_valid", int'(txv), ev);
      check("m_busy", int'(busy), ev);
      check("m_empty", int'(empty), (m_fifo.size() == 0) ? 1 : 0);
      check("m_full", int'(full), (m_fifo.size() == DEPTH) ? 1 : 0);
      check("m_overflow", int'(ovf), int'(m_ovf));
      check("m_state", int'(dst), es);
      if (ev == 1) check("m_tx_byte", int'(txb), int'(m_out[0]));
   endtask

   task automatic step();
      if (txv && rdy) got.push_back(txb);
      @(posedge clk);
      model_edge();
      #1;
      model_compare();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      push  = 1'b0;
      rdy   = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic push_burst(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         push = 1'b1;
         code = base + 8'(i);
         data = {8'(8'h10 + i), 8'(8'h20 + i)};
         step();
      end
      push = 1'b0;
   endtask

   initial begin
      logic       pv, pr;
      logic [7:0] pb;
      int         n;
      int         ppush, prdy;

      rst_n = 1'b0; push = 1'b0; rdy = 1'b0; code = 8'h00; data = '0;
      push8 = 1'b0; rdy8 = 1'b0; code8 = 8'h00; data8 = 8'h00;
      m_ovf = 1'b0;
      step();
      step();
      check("rst_tx_valid", int'(txv), 0);
      check("rst_tx_byte", int'(txb), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_full", int'(full), 0);
      check("rst_overflow", int'(ovf), 0);
      check("rst_state", int'(dst), 0);
      rst_n = 1'b1;

      // single frame, tx_ready high: 11 20 40 71
      tbl[0] = '{1'b1, 8'h11, 16'h2040, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
      tbl[1] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h11, 1'b1, 2'd1};
      tbl[2] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h20, 1'b1, 2'd2};
      tbl[3] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h40, 1'b1, 2'd2};
      tbl[4] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h71, 1'b1, 2'd3};
      tbl[5] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
      tbl[6] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
      for (int i = 0; i < 7; i++) begin
         push = tbl[i].p; code = tbl[i].c; data = tbl[i].d; rdy = tbl[i].r;
         step();
         check($sformatf("t1_valid[%0d]", i), int'(txv), int'(tbl[i].ev));
         check($sformatf("t1_empty[%0d]", i), int'(empty), int'(tbl[i].ee));
         check($sformatf("t1_state[%0d]", i), int'(dst), int'(tbl[i].es));
         if (tbl[i].ev) check($sformatf("t1_byte[%0d]", i), int'(txb), int'(tbl[i].eb));
      end
      push = 1'b0;

      // tx_ready toggling: stable under stall, same sequence, no duplicates
      do_reset();
      got.delete();
      push = 1'b1; code = 8'h11; data = 16'h2040; rdy = 1'b0;
      step();
      push = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rdy = i[0];
         pv = txv; pr = rdy; pb = txb;
         step();
         if (pv && !pr) begin
            check("t2_hold_valid", int'(txv), 1);
            check("t2_hold_byte", int'(txb), int'(pb));
         end
      end
      check("t2_count", got.size(), 4);
      if (got.size() == 4) begin
         check("t2_b0", int'(got[0]), 'h11);
         check("t2_b1", int'(got[1]), 'h20);
         check("t2_b2", int'(got[2]), 'h40);
         check("t2_b3", int'(got[3]), 'h71);
      end
      check("t2_empty", int'(empty), 1);

      // fill with tx_ready low: first entry sits in the frame register, four more fill the FIFO
      do_reset();
      for (int i = 0; i < 6; i++) begin
         push = 1'b1;
         code = 8'hA0 + 8'(i);
         data = {8'(8'h10 + i), 8'(8'h20 + i)};
         step();
         if (i == 4) begin
            check("t3_full", int'(full), 1);
            check("t3_no_ovf_yet", int'(ovf), 0);
         end
      end
      push = 1'b0;
      check("t3_overflow", int'(ovf), 1);
      got.delete();
      rdy = 1'b1;
      repeat (40) step();
      check("t3_bytes", got.size(), 5 * FLEN);
      if (got.size() == 5 * FLEN)
         for (int k = 0; k < 5; k++) check($sformatf("t3_code[%0d]", k), int'(got[FLEN*k]), 'hA0 + k);

      // push into a full FIFO on the very cycle IDLE pops
      do_reset();
      push_burst(5, 8'hB0);
      check("t4_full", int'(full), 1);
      rdy = 1'b1;
      n = 0;
      while (dst != 2'd3 && n < 10) begin
         step();
         n++;
      end
      check("t4_reach_csum", int'(dst), 3);
      step();
      check("t4_idle", int'(dst), 0);
      check("t4_full_idle", int'(full), 1);
      push = 1'b1; code = 8'hC5; data = 16'h1234;
      got.delete();
      step();
      push = 1'b0;
      check("t4_full_after", int'(full), 1);
      check("t4_ovf", int'(ovf), 0);
      check("t4_state", int'(dst), 1);
      check("t4_byte", int'(txb), 'hB1);
      repeat (40) step();
      check("t4_bytes", got.size(), 5 * FLEN);
      if (got.size() == 5 * FLEN) check("t4_last_code", int'(got[4*FLEN]), 'hC5);

      // reset during DATA with two entries queued
      do_reset();
      push_burst(3, 8'hD0);
      rdy = 1'b1;
      step();
      check("t5_in_data", int'(dst), 2);
      rst_n = 1'b0;
      step();
      check("t5_valid", int'(txv), 0);
      check("t5_empty", int'(empty), 1);
      check("t5_state", int'(dst), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("t5_quiet", int'(txv), 0);
      end

      // 8-bit data, no checksum: 22 05 then idle
      push8 = 1'b1; code8 = 8'h22; data8 = 8'h05; rdy8 = 1'b1;
      step();
      push8 = 1'b0;
      check("t6_empty", int'(empty8), 0);
      step();
      check("t6_v0", int'(txv8), 1);
      check("t6_b0", int'(txb8), 'h22);
      check("t6_s0", int'(dst8), 1);
      step();
      check("t6_v1", int'(txv8), 1);
      check("t6_b1", int'(txb8), 'h05);
      check("t6_busy1", int'(busy8), 1);
      step();
      check("t6_v2", int'(txv8), 0);
      check("t6_busy2", int'(busy8), 0);
      check("t6_s2", int'(dst8), 0);
      check("t6_full", int'(full8), 0);
      check("t6_ovf", int'(ovf8), 0);
      step();
      check("t6_v3", int'(txv8), 0);

      // randomized traffic against the model
      do_reset();
      for (int seg = 0; seg < 3; seg++) begin
         ppush = (seg == 0) ? 20 : (seg == 1) ? 50 : 90;
         prdy  = (seg == 0) ? 90 : (seg == 1) ? 50 : 25;
         for (int i = 0; i < 800; i++) begin
            push  = ($urandom_range(99) < ppush);
            code  = 8'($urandom);
            data  = DW'($urandom);
            rdy   = ($urandom_range(99) < prdy);
            rst_n = ($urandom_range(499) != 0);
            step();
         end
      end
      rst_n = 1'b1;
      push  = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
